// File: rtl/timer_a_count.sv
// Timer_A TAxR next-count logic: decodes MC, EQU0 and TACLR into the next
// counter value and the TAIFG set request. Only the up/down direction is stored.
module timer_a_count (
  input  logic        TimerClock,
  input  logic        reset,
  input  logic        wTACLR,
  input  logic [1:0]  MC,
  input  logic        EQU0,
  input  logic [15:0] TAxRcurrent,
  output logic [15:0] TAxRnew,
  output logic        TAIFGset
);

  typedef enum logic [1:0] {
    MC_STOP   = 2'b00,
    MC_UP     = 2'b01,
    MC_CONT   = 2'b10,
    MC_UPDOWN = 2'b11
  } mc_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  dir_e        r_dir;
  dir_e        w_dir_next;
  logic [15:0] w_inc;
  logic [15:0] w_dec;
  logic        w_is_zero;
  logic        w_is_one;
  logic        w_is_max;

  assign w_inc     = TAxRcurrent + 16'd1;
  assign w_dec     = TAxRcurrent - 16'd1;
  assign w_is_zero = (TAxRcurrent == 16'h0000);
  assign w_is_one  = (TAxRcurrent == 16'h0001);
  assign w_is_max  = (TAxRcurrent == 16'hFFFF);

  // NOTE: non-blocking assignment for the state register so every clocked
  // process samples the pre-edge value of r_dir.
  always_ff @(posedge TimerClock or posedge reset) begin
    if (reset) r_dir <= DIR_UP;
    else       r_dir <= w_dir_next;
  end

  always_comb begin
    // NOTE: defaults first so every path drives all outputs and no latch is inferred.
    TAxRnew    = TAxRcurrent;
    TAIFGset   = 1'b0;
    w_dir_next = r_dir;

    if (reset || wTACLR) begin
      TAxRnew    = 16'h0000;
      w_dir_next = DIR_UP;
    end else begin
      case (mc_e'(MC))
        MC_STOP: begin
          TAxRnew = TAxRcurrent;
        end
        MC_UP: begin
          w_dir_next = DIR_UP;
          if (EQU0) begin
            // CCR0 == 0 halts the timer without a flag
            TAxRnew  = 16'h0000;
            TAIFGset = !w_is_zero;
          end else begin
            TAxRnew = w_inc;
          end
        end
        MC_CONT: begin
          w_dir_next = DIR_UP;
          TAxRnew    = w_inc;
          TAIFGset   = w_is_max;
        end
        MC_UPDOWN: begin
          if (r_dir == DIR_UP) begin
            if (EQU0 && !w_is_zero) begin
              TAxRnew    = w_dec;
              w_dir_next = DIR_DOWN;
            end else if (EQU0) begin
              TAxRnew = 16'h0000;
            end else begin
              TAxRnew = w_inc;
            end
          end else begin
            // Flag fires on the 1 -> 0 step; turnaround happens one count later
            if (w_is_one) begin
              TAxRnew  = 16'h0000;
              TAIFGset = 1'b1;
            end else if (w_is_zero) begin
              TAxRnew    = 16'h0001;
              w_dir_next = DIR_UP;
            end else begin
              TAxRnew = w_dec;
            end
          end
        end
        default: begin
          TAxRnew = TAxRcurrent;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_a_count.sv
// Self-checking bench for timer_a_count: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the counting rules.
module tb_timer_a_count;

  logic        TimerClock;
  logic        reset;
  logic        wTACLR;
  logic [1:0]  MC;
  logic        EQU0;
  logic [15:0] TAxRcurrent;
  logic [15:0] TAxRnew;
  logic        TAIFGset;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 1 while the UPDOWN count is heading toward zero.
  bit m_down = 1'b0;

  timer_a_count dut (
    .TimerClock  (TimerClock),
    .reset       (reset),
    .wTACLR      (wTACLR),
    .MC          (MC),
    .EQU0        (EQU0),
    .TAxRcurrent (TAxRcurrent),
    .TAxRnew     (TAxRnew),
    .TAIFGset    (TAIFGset)
  );

  initial TimerClock = 1'b0;
  always #5 TimerClock = ~TimerClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: what TAxR becomes, whether TAIFG is requested, and the next direction.
  function automatic void ref_next(input int mode, input bit eq, input int cur,
                                   input bit clear, input bit down,
                                   output int nv, output bit flag, output bit nd);
    nv = cur; flag = 0; nd = down;
    if (clear) begin
      nv = 0; nd = 0;
    end else if (mode == 0) begin
      nv = cur;
    end else if (mode == 1) begin
      nd = 0;
      if (eq) begin nv = 0; flag = (cur != 0); end
      else nv = (cur + 1) % 65536;
    end else if (mode == 2) begin
      nd = 0;
      nv = (cur + 1) % 65536;
      flag = (cur == 65535);
    end else if (!down) begin
      if (eq && cur != 0) begin nv = cur - 1; nd = 1; end
      else if (eq)        nv = 0;
      else                nv = (cur + 1) % 65536;
    end else begin
      if (cur == 1)      begin nv = 0; flag = 1; end
      else if (cur == 0) begin nv = 1; nd = 0; end
      else               nv = cur - 1;
    end
  endfunction

  // Drive one TimerClock cycle: inputs change at the falling edge, outputs are
  // checked 1 ns later, and the model direction advances at the rising edge.
  task automatic step(input string tag, input int mode, input bit eq, input int cur,
                      input bit clr, input bit rst);
    int nv; bit flag; bit nd;
    @(negedge TimerClock);
    reset       = rst;
    wTACLR      = clr;
    MC          = mode[1:0];
    EQU0        = eq;
    TAxRcurrent = cur[15:0];
    if (rst) m_down = 1'b0;
    #1;
    ref_next(mode, eq, cur, clr || rst, m_down, nv, flag, nd);
    check({tag, ".new"}, {16'h0, TAxRnew}, nv);
    check({tag, ".ifg"}, {31'h0, TAIFGset}, {31'h0, flag});
    @(posedge TimerClock);
    m_down = rst ? 1'b0 : nd;
  endtask

  initial begin
    reset = 1'b1; wTACLR = 1'b0; MC = 2'b01; EQU0 = 1'b0; TAxRcurrent = 16'd5;
    #1;
    check("reset.new", {16'h0, TAxRnew}, 32'h0);
    check("reset.ifg", {31'h0, TAIFGset}, 32'h0);

    // STOP holds the count, ignores EQU0; clear and reset force zero
    step("stop0",    0, 0, 0,     0, 0);
    step("stop10",   0, 0, 10,    0, 0);
    step("stopmax",  0, 0, 65535, 0, 0);
    step("stopeq",   0, 1, 65535, 0, 0);
    step("stopclr",  0, 0, 65535, 1, 0);
    step("stoprst",  0, 0, 65535, 0, 1);

    // UP
    step("up0",      1, 0, 0,     0, 0);
    step("up10",     1, 0, 10,    0, 0);
    step("upmax",    1, 0, 65535, 0, 0);
    step("upeq",     1, 1, 1000,  0, 0);
    step("uppost",   1, 0, 1000,  0, 0);
    step("upeq0",    1, 1, 0,     0, 0);

    // CONTINUOUS
    step("cont0",    2, 0, 0,     0, 0);
    step("cont10",   2, 0, 10,    0, 0);
    step("contmax",  2, 0, 65535, 0, 0);
    step("conteq",   2, 1, 1000,  0, 0);

    // UPDOWN turnaround at CCR0 and at zero, STOP preserving direction
    step("ud_eq",    3, 1, 1000,  0, 0);
    step("ud_dn10",  3, 0, 10,    0, 0);
    step("stop_dn",  0, 0, 10,    0, 0);
    step("ud_dn10b", 3, 1, 10,    0, 0);
    step("ud_dn1",   3, 0, 1,     0, 0);
    step("ud_dn0",   3, 0, 0,     0, 0);
    step("ud_up10",  3, 0, 10,    0, 0);
    step("ud_upmax", 3, 0, 65535, 0, 0);
    step("ud_eq0",   3, 1, 0,     0, 0);

    // Clear while counting down
    step("ud_eq2",   3, 1, 500,   0, 0);
    step("ud_clr",   3, 0, 499,   1, 0);
    step("ud_aclr",  3, 0, 10,    0, 0);

    // Leaving UPDOWN for UP clears the direction
    step("ud_eq3",   3, 1, 300,   0, 0);
    step("up_leave", 1, 0, 299,   0, 0);
    step("ud_back",  3, 0, 10,    0, 0);

    // Asynchronous reset pulse between edges while counting down
    step("ud_eq4",   3, 1, 200,   0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst.new", {16'h0, TAxRnew}, 32'h0);
    check("arst.ifg", {31'h0, TAIFGset}, 32'h0);
    m_down = 1'b0;
    reset = 1'b0;
    step("arst_up",  3, 0, 10,    0, 0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      int sel; int cur;
      sel = $urandom_range(0, 7);
      case (sel)
        0: cur = 0;
        1: cur = 1;
        2: cur = 65535;
        3: cur = 65534;
        4: cur = 2;
        default: cur = $urandom_range(0, 65535);
      endcase
      step("rand", $urandom_range(0, 3), ($urandom_range(0, 3) == 0), cur,
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_a_count.md
Name: timer_a_count

Overview:
- Next-count logic for the MSP430 Timer_A counter (TAxR).
- Each TimerClock cycle it takes the current TAxR value, the mode control (MC), the CCR0-equal flag (EQU0) and the TACLR request. It produces the value TAxR loads on the next TimerClock edge, plus a one-cycle TAIFG set request.
- The only internal state is the up/down direction bit used in UPDOWN mode. The TAxR register and the TAIFG flag themselves live in the parent Timer_A block.

Parameters:
- None. Counter width is fixed at 16 bits.

Ports:
- TimerClock  in  1  timer clock; direction register updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wTACLR  in  1  TACLR write strobe; clears count and direction.
- MC  in  2  mode control: 00 STOP, 01 UP, 10 CONTINUOUS, 11 UPDOWN (MC__* constants from PARAMS.v).
- EQU0  in  1  high when TAxR == TAxCCR0.
- TAxRcurrent  in  16  present TAxR value.
- TAxRnew  out  16  value TAxR loads at the next TimerClock edge.
- TAIFGset  out  1  request to set TAIFG at the next TimerClock edge.

Behaviour:
- One clock (TimerClock); reset is asynchronous and active-high.
- State: dir register (0 = up, 1 = down).
  - reset high: dir = 0 immediately.
  - Rising TimerClock edge with wTACLR high: dir <= 0.
- Outputs are combinational from the inputs and dir; zero latency.
- Priority: reset > wTACLR > MC decode.
- reset or wTACLR high: TAxRnew = 0, TAIFGset = 0, regardless of MC or EQU0.
- STOP (00):
  - TAxRnew = TAxRcurrent, TAIFGset = 0.
  - dir holds.
- UP (01):
  - EQU0 = 1 and TAxRcurrent != 0: TAxRnew = 0, TAIFGset = 1 (CCR0 -> 0 rollover).
  - EQU0 = 1 and TAxRcurrent == 0 (CCR0 = 0, timer halted): TAxRnew = 0, TAIFGset = 0.
  - EQU0 = 0: TAxRnew = TAxRcurrent + 1 (mod 2^16, so FFFF wraps to 0000), TAIFGset = 0.
  - dir <= 0 on each clock edge.
- CONTINUOUS (10):
  - TAxRnew = TAxRcurrent + 1 mod 2^16. EQU0 is ignored.
  - TAIFGset = 1 only when TAxRcurrent == FFFF.
  - dir <= 0 on each clock edge.
- UPDOWN (11), dir = 0 (counting up):
  - EQU0 = 1 and TAxRcurrent != 0: TAxRnew = TAxRcurrent - 1; dir <= 1 on the clock edge.
  - EQU0 = 1 and TAxRcurrent == 0: hold at 0, dir unchanged, TAIFGset = 0.
  - Otherwise: TAxRnew = TAxRcurrent + 1 mod 2^16 (FFFF -> 0 wraps, no flag).
  - TAIFGset = 0 in all up-direction cases.
- UPDOWN (11), dir = 1 (counting down):
  - TAxRcurrent == 1: TAxRnew = 0, TAIFGset = 1.
  - TAxRcurrent == 0: TAxRnew = 1, TAIFGset = 0; dir <= 0 on the clock edge.
  - Otherwise: TAxRnew = TAxRcurrent - 1, TAIFGset = 0. EQU0 is ignored while counting down.
- Mode changes: leaving UPDOWN for UP or CONTINUOUS clears dir on the next edge. STOP preserves dir, so UPDOWN resumes in the same direction.
- All arithmetic is 16-bit unsigned with natural wrap.
- TAIFGset is never asserted in the same cycle as reset or wTACLR.

Test Plan:
- STOP, TAxRcurrent = 0, 10, FFFF, then pulse EQU0 -> TAxRnew tracks TAxRcurrent (0, 10, FFFF), TAIFGset = 0; pulsing wTACLR or reset -> TAxRnew = 0.
- UP, TAxRcurrent = 0 / 10 / FFFF -> TAxRnew = 1 / 11 / 0 with TAIFGset = 0; TAxRcurrent = 1000 with EQU0 pulsed -> TAxRnew = 0, TAIFGset = 1 during the pulse, back to 1001 / 0 afterwards.
- CONTINUOUS, TAxRcurrent = 0 / 10 / FFFF -> TAxRnew = 1 / 11 / 0; TAIFGset = 1 only at FFFF; EQU0 pulsed at 1000 -> TAxRnew = 1001, no flag.
- UPDOWN: at 1000 with EQU0 pulsed -> TAxRnew = 999 and dir = 1 after the edge; then TAxRcurrent = 10 -> 9; TAxRcurrent = 1 -> 0 with TAIFGset = 1; TAxRcurrent = 0 -> 1 and dir returns to 0.
- wTACLR pulsed in UPDOWN while dir = 1 -> TAxRnew = 0 during the pulse; after the edge dir = 0, so TAxRcurrent = 10 gives TAxRnew = 11.
- reset asserted mid-cycle between edges -> dir clears immediately and TAxRnew = 0 with no clock; after release, UPDOWN counts up.
